// File: rtl/lab6_pkg.sv
// Shared definitions for the lab6 PISO transmitter.
// Build option: LAB6_PISO_PARITY_EN adds an even-parity bit after the data bits.
package lab6_pkg;

   localparam int unsigned DATA_W           = 4;
   localparam int unsigned FRAME_BITS_NOPAR = 6;   // start + 4 data + stop
   localparam int unsigned FRAME_BITS_PAR   = 7;   // start + 4 data + parity + stop

`ifdef LAB6_PISO_PARITY_EN
   localparam int unsigned FRAME_BITS = FRAME_BITS_PAR;
`else
   localparam int unsigned FRAME_BITS = FRAME_BITS_NOPAR;
`endif

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3
`ifdef LAB6_PISO_PARITY_EN
      , ST_PARITY = 3'd4
`endif
   } state_e;

`ifdef LAB6_PISO_PARITY_EN
   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction
`endif

endpackage

// File: rtl/lab6_bit_timer.sv
// Bit-period counter: counts BIT_CYCLES clocks per serial bit and flags the
// last cycle of each period. restart_i holds the count at zero so the first
// period after a restart is a full one.
module lab6_bit_timer #(
   parameter int unsigned BIT_CYCLES = 2
) (
   input  logic Clk,
   input  logic reset,
   input  logic restart_i,
   output logic tick_o
);

   localparam logic [7:0] LAST_CNT = 8'(BIT_CYCLES - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: clear on restart, wrap at the end of a period, else advance.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = 8'd0;
      end else if (cnt_q == LAST_CNT) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register with asynchronous clear.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST_CNT) && !restart_i;

endmodule

// File: rtl/lab6_piso_tx.sv
// 4-bit parallel-in serial-out transmitter: start(0), D[0..3] LSB first,
// optional even parity, stop(1); every bit lasts BIT_CYCLES clocks.
// Build option: LAB6_PISO_PARITY_EN enables the parity bit and PARITY state.
module lab6_piso_tx
   import lab6_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] D,
   output logic              SO,
   output logic              ready,
   output logic              done
);

   localparam logic [1:0] LAST_IDX = 2'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [1:0]        idx_q,   idx_d;
   logic              so_q,    so_d;
   logic              ready_q, ready_d;
   logic              done_q,  done_d;
   logic              tick_s;
   logic              restart_s;
`ifdef LAB6_PISO_PARITY_EN
   logic              par_q,   par_d;
`endif

   // The timer idles at zero so a frame starts with a full start-bit period.
   assign restart_s = (state_q == ST_IDLE);

   lab6_bit_timer #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_bit_timer (
      .Clk      (Clk),
      .reset    (reset),
      .restart_i(restart_s),
      .tick_o   (tick_s)
   );

   // Next-state, shift register and bit index; outputs derive from next state
   // so they can be registered without an extra cycle of latency.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
`ifdef LAB6_PISO_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_START;
               shift_d = D;
               idx_d   = 2'd0;
`ifdef LAB6_PISO_PARITY_EN
               par_d   = even_parity(D);
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               if (idx_q == LAST_IDX) begin
`ifdef LAB6_PISO_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
                  idx_d   = 2'd0;
               end else begin
                  shift_d = {1'b0, shift_q[DATA_W-1:1]};
                  idx_d   = idx_q + 2'd1;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef LAB6_PISO_PARITY_EN
         ST_PARITY: begin
            if (tick_s) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (tick_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_IDLE:   so_d = 1'b1;
         ST_START:  so_d = 1'b0;
         ST_DATA:   so_d = shift_d[0];
`ifdef LAB6_PISO_PARITY_EN
         ST_PARITY: so_d = par_d;
`endif
         ST_STOP:   so_d = 1'b1;
         default:   so_d = 1'b1;
      endcase

      ready_d = (state_d == ST_IDLE);
      done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
   end

   // State and registered outputs; reset returns the line to idle-high.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         idx_q   <= 2'd0;
         so_q    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         so_q    <= so_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

`ifdef LAB6_PISO_PARITY_EN
   // Parity bit captured with the data word at acceptance.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

   assign SO    = so_q;
   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_lab6_piso_tx.sv
// Self-checking bench for lab6_piso_tx: vector table, corner sequences and
// random traffic against a frame-queue reference model.
module tb_lab6_piso_tx;
   import lab6_pkg::*;

   localparam int unsigned BC = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       load_s = 1'b0;
   logic [3:0] d_s = 4'd0;
   logic       so_s, ready_s, done_s;
   logic       load1_s = 1'b0;
   logic [3:0] d1_s = 4'd0;
   logic       so1_s, ready1_s, done1_s;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a queue of expected SO cycles for the frame in flight.
   logic exp_q[$];
   bit   busy = 1'b0;
   logic exp_so = 1'b1, exp_ready = 1'b1, exp_done = 1'b0;

   typedef struct {
      logic [3:0] d;
      logic [5:0] np;    // expected bits, index 0 first, no parity
      logic [6:0] par;   // expected bits, index 0 first, with parity
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   lab6_piso_tx #(.BIT_CYCLES(BC)) u_dut (
      .Clk(clk), .reset(rst_n), .load(load_s), .D(d_s),
      .SO(so_s), .ready(ready_s), .done(done_s)
   );

   lab6_piso_tx #(.BIT_CYCLES(1)) u_dut1 (
      .Clk(clk), .reset(rst_n), .load(load1_s), .D(d1_s),
      .SO(so1_s), .ready(ready1_s), .done(done1_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Build the expected SO stream of one frame from the frame format.
   task automatic model_accept(input logic [3:0] d);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 4; i++) bits.push_back(d[i]);
`ifdef LAB6_PISO_PARITY_EN
      bits.push_back(^d);
`endif
      bits.push_back(1'b1);
      foreach (bits[i])
         for (int c = 0; c < int'(BC); c++) exp_q.push_back(bits[i]);
   endtask

   // Advance the model by one rising edge using the inputs present at it.
   task automatic model_edge();
      if (busy) begin
         if (exp_q.size() > 0) begin
            exp_so = exp_q.pop_front(); exp_ready = 1'b0; exp_done = 1'b0;
         end else begin
            busy = 1'b0; exp_so = 1'b1; exp_ready = 1'b1; exp_done = 1'b1;
         end
      end else if (load_s) begin
         model_accept(d_s);
         busy = 1'b1;
         exp_so = exp_q.pop_front(); exp_ready = 1'b0; exp_done = 1'b0;
      end else begin
         exp_so = 1'b1; exp_ready = 1'b1; exp_done = 1'b0;
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check({tag, " so/ready/done"}, {29'd0, so_s, ready_s, done_s},
            {29'd0, exp_so, exp_ready, exp_done});
   endtask

   // Assert reset between edges, check it acts at once, release on a falling edge.
   task automatic apply_reset();
      #3 rst_n = 1'b0;
      #1;
      check("reset immediate", {29'd0, so_s, ready_s, done_s}, 32'd6);
      check("reset immediate dut1", {29'd0, so1_s, ready1_s, done1_s}, 32'd6);
      exp_q.delete(); busy = 1'b0;
      exp_so = 1'b1; exp_ready = 1'b1; exp_done = 1'b0;
      @(posedge clk); #1;
      check("reset held", {29'd0, so_s, ready_s, done_s}, 32'd6);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [6:0] fb;
      logic [6:0] fb1;
      int dones;

      tbl[0] = '{4'b0101, 6'b101010, 7'b1001010};
      tbl[1] = '{4'b0111, 6'b101110, 7'b1101110};
      tbl[2] = '{4'b1001, 6'b110010, 7'b1010010};
      tbl[3] = '{4'b0000, 6'b100000, 7'b1000000};
      tbl[4] = '{4'b1111, 6'b111110, 7'b1011110};
      tbl[5] = '{4'b1000, 6'b110000, 7'b1110000};

      apply_reset();

      // Table: one frame per entry, bit-exact SO, then done with ready.
      for (int i = 0; i < 6; i++) begin
`ifdef LAB6_PISO_PARITY_EN
         fb = tbl[i].par;
`else
         fb = {1'b0, tbl[i].np};
`endif
         load_s = 1'b1; d_s = tbl[i].d;
         step("tbl accept");
         load_s = 1'b0; d_s = ~tbl[i].d;
         for (int b = 0; b < int'(FRAME_BITS); b++) begin
            for (int c = 0; c < int'(BC); c++) begin
               if (b != 0 || c != 0) step("tbl frame");
               check("tbl so bit", {31'd0, so_s}, {31'd0, fb[b]});
            end
         end
         step("tbl end");
         check("tbl done+ready", {30'd0, done_s, ready_s}, 32'd3);
         step("tbl idle");
         check("tbl done drops", {31'd0, done_s}, 32'd0);
      end

      // Load during DATA is ignored: one frame only, ready stays low.
      load_s = 1'b1; d_s = 4'b0101;
      step("ign accept");
      load_s = 1'b0;
      repeat (5) step("ign pre");
      load_s = 1'b1; d_s = 4'b1001;
      dones = 0;
      repeat (3) begin
         step("ign busy");
         check("ign ready low", {31'd0, ready_s}, 32'd0);
      end
      load_s = 1'b0;
      repeat (int'(FRAME_BITS * BC) + 4) begin
         step("ign post");
         if (done_s === 1'b1) dones++;
      end
      check("ign single done", dones, 32'd1);

      // Reset mid-DATA aborts without done; next load sends a full frame.
      load_s = 1'b1; d_s = 4'b0101;
      step("rst accept");
      load_s = 1'b0;
      repeat (5) step("rst pre");
      load_s = 1'b1; d_s = 4'b0110;
      apply_reset();
      step("rst reaccept");
      check("rst first edge accepts", {31'd0, so_s}, 32'd0);
      load_s = 1'b0;
      repeat (int'(FRAME_BITS * BC) + 2) step("rst frame");

      // Back-to-back frames on the single-cycle-bit instance.
`ifdef LAB6_PISO_PARITY_EN
      fb1 = 7'b1000110;
`else
      fb1 = 7'b0100110;
`endif
      load1_s = 1'b1; d1_s = 4'b0011;
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < int'(FRAME_BITS); b++) begin
            step("b2b");
            check("b2b so/ready/done", {29'd0, so1_s, ready1_s, done1_s},
                  {29'd0, fb1[b], 2'b00});
         end
         step("b2b gap");
         check("b2b idle gap", {29'd0, so1_s, ready1_s, done1_s}, 32'd7);
      end
      load1_s = 1'b0;
      step("b2b stop");
      check("b2b stays idle", {29'd0, so1_s, ready1_s, done1_s}, 32'd6);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         load_s = ($urandom_range(0, 3) == 0);
         d_s    = 4'($urandom);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lab6_piso_tx.md
LAB6_PISO_TX -- requirements
Module: lab6_piso_tx

Interface
- REQ-001: Parameter BIT_CYCLES, default 2: clock cycles per serial bit period; legal range 1..255.
- REQ-002: Clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: load  input  1  request to transmit D; sampled on rising Clk.
- REQ-005: D  input  4  parallel data word to serialise.
- REQ-006: SO  output  1  serial line; idles high.
- REQ-007: ready  output  1  high when a load will be accepted.
- REQ-008: done  output  1  one-cycle pulse marking the end of a frame.

Function
- REQ-009: Frame format SHALL be: start bit (0), D[0], D[1], D[2], D[3] (LSB first), optional parity bit (REQ-024), stop bit (1).
- REQ-010: Each bit SHALL be driven on SO for exactly BIT_CYCLES consecutive clock cycles.
- REQ-011: FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- REQ-012: Load acceptance: in IDLE, load=1 at a rising edge SHALL capture D into the shift register and move to START.
- REQ-013: In START, SO SHALL be 0 from the first edge after acceptance, a 1-cycle latency.
- REQ-014: In START, ready SHALL fall on that same edge.
- REQ-015: START->DATA after BIT_CYCLES cycles; DATA holds 4 bit periods, shifting right once per period.
- REQ-016: DATA exit: ->PARITY when parity is compiled in, otherwise ->STOP.
- REQ-017: PARITY holds one bit period and then moves to STOP.
- REQ-018: STOP holds SO=1 for BIT_CYCLES cycles, then returns to IDLE.
- REQ-019: done SHALL pulse high for exactly the one cycle in which IDLE is entered from STOP.
- REQ-020: ready SHALL be high only in IDLE.
- REQ-021: Total frame length SHALL be 6*BIT_CYCLES cycles (7*BIT_CYCLES with parity), measured from the first SO=0 cycle to the first cycle of IDLE.
- REQ-022: A load asserted while ready=0 SHALL be ignored: no queuing, and the frame in progress and D captured for it are unaffected. D changes after acceptance SHALL NOT affect the frame.
- REQ-023: Back-to-back frames: load held high continuously SHALL start the next frame on the edge after done, giving exactly one idle-high cycle between frames.

Configuration
- REQ-024: Macro LAB6_PISO_PARITY_EN is the only build option.
- REQ-025: With LAB6_PISO_PARITY_EN defined, an even-parity bit (XOR of D[3:0]) SHALL be sent in PARITY.
- REQ-026: Without LAB6_PISO_PARITY_EN, the PARITY state and the parity logic SHALL be absent, and DATA SHALL go directly to STOP.

Reset
- REQ-027: reset=0 SHALL immediately, without waiting for Clk, force state=IDLE, SO=1, ready=1, done=0, shift register=0, bit-period counter=0 and bit index=0.
- REQ-028: Reset asserted mid-frame SHALL abort the frame with no done pulse.
- REQ-029: After reset deassertion, the first rising edge SHALL be able to accept a load.

Structure
- REQ-030: Shared package lab6_pkg SHALL hold the FSM state enum, the data width constant (4) and the frame-bit-count constants (with and without parity).
- REQ-031: Sub-module lab6_bit_timer SHALL implement the bit-period counter.
- REQ-032: lab6_bit_timer SHALL take Clk, reset, a restart input and BIT_CYCLES, and SHALL emit a one-cycle tick at the end of each bit period.

Verification
- REQ-033: BIT_CYCLES=2, no parity, D=4'b0101, load pulse in IDLE -> SO = 0,0,1,1,0,0,1,1,0,0,1,1, then done=1 with ready=1 on the following cycle.
- REQ-034: Parity build, D=4'b0111 -> parity period SO=1; D=4'b1001 -> parity period SO=0; frame length 14 cycles.
- REQ-035: load=1 with D=4'b1001 during DATA of a 4'b0101 frame -> 4'b0101 frame unchanged, no second frame, ready stays 0 until done.
- REQ-036: reset=0 mid-DATA, asserted between clock edges -> SO=1 and ready=1 immediately, done never pulses; the next load after release sends a full frame.
- REQ-037: load held high, D=4'b0011, BIT_CYCLES=1 -> continuous frames 0,1,1,0,0,1 separated by exactly one SO=1 idle cycle, with done pulsing once per frame.
